// File: rtl/name_decoder.sv
// Identifier name decoder: turns "__0HH" escapes back into the raw byte 0xHH
// and passes everything else through literally. Aborted escape prefixes are
// replayed from a small pending buffer, and the byte that broke the escape is
// held and re-parsed from IDLE once the replay is done.
module name_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [CNT_W-1:0] seq_count,
   output logic [CNT_W-1:0] lit_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      U1    = 3'd1,
      U2    = 3'd2,
      Z     = 3'd3,
      H1    = 3'd4,
      FLUSH = 3'd5
   } state_t;

   // {valid, nibble} for an ASCII hex digit
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

   state_t           state_reg, state_next;
   logic [7:0]       pend_reg [0:3];
   logic [7:0]       pend_next [0:3];
   logic [2:0]       pend_cnt_reg, pend_cnt_next;
   logic [1:0]       flush_idx_reg, flush_idx_next;
   logic             flush_last_reg, flush_last_next;
   logic [7:0]       held_reg, held_next;
   logic             held_last_reg, held_last_next;
   logic             held_valid_reg, held_valid_next;
   logic [3:0]       nib_reg, nib_next;
   logic             out_valid_reg, out_valid_next;
   logic [7:0]       out_data_reg, out_data_next;
   logic             out_last_reg, out_last_next;
   logic [CNT_W-1:0] seq_reg, seq_next;
   logic [CNT_W-1:0] lit_reg, lit_next;

   logic             can_load;
   logic             cur_fire;
   logic [7:0]       cur_data;
   logic             cur_last;
   logic [4:0]       cur_hex;
   logic [2:0]       last_idx;

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Pending prefix buffer, one register per slot
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pend
         // Capture an appended prefix byte; cleared by reset
         always_ff @(posedge clk) begin
            if (rst)
               pend_reg[gi] <= 8'h00;
            else
               pend_reg[gi] <= pend_next[gi];
         end
      end
   endgenerate

   // Datapath, output register and statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_cnt_reg   <= 3'd0;
         flush_idx_reg  <= 2'd0;
         flush_last_reg <= 1'b0;
         held_reg       <= 8'h00;
         held_last_reg  <= 1'b0;
         held_valid_reg <= 1'b0;
         nib_reg        <= 4'd0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= 8'h00;
         out_last_reg   <= 1'b0;
         seq_reg        <= '0;
         lit_reg        <= '0;
      end else begin
         pend_cnt_reg   <= pend_cnt_next;
         flush_idx_reg  <= flush_idx_next;
         flush_last_reg <= flush_last_next;
         held_reg       <= held_next;
         held_last_reg  <= held_last_next;
         held_valid_reg <= held_valid_next;
         nib_reg        <= nib_next;
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         out_last_reg   <= out_last_next;
         seq_reg        <= seq_next;
         lit_reg        <= lit_next;
      end
   end

   // Handshake and current-byte selection (held byte takes priority over input)
   always_comb begin
      can_load = !out_valid_reg || out_ready;
      in_ready = !rst && can_load && (state_reg != FLUSH) && !held_valid_reg;
      cur_data = held_valid_reg ? held_reg : in_data;
      cur_last = held_valid_reg ? held_last_reg : in_last;
      cur_fire = held_valid_reg ? (can_load && state_reg == IDLE)
                                : (in_valid && in_ready);
      cur_hex  = hex_decode(cur_data);
      last_idx = pend_cnt_reg - 3'd1;
   end

   // Next-state and datapath update
   always_comb begin
      state_next      = state_reg;
      for (int i = 0; i < 4; i++) pend_next[i] = pend_reg[i];
      pend_cnt_next   = pend_cnt_reg;
      flush_idx_next  = flush_idx_reg;
      flush_last_next = flush_last_reg;
      held_next       = held_reg;
      held_last_next  = held_last_reg;
      held_valid_next = held_valid_reg;
      nib_next        = nib_reg;
      out_valid_next  = out_valid_reg && !out_ready;
      out_data_next   = out_data_reg;
      out_last_next   = out_last_reg;
      seq_next        = seq_reg;
      lit_next        = lit_reg;

      if (state_reg == FLUSH) begin
         // Replay one pending byte per free output slot
         if (can_load) begin
            out_valid_next = 1'b1;
            out_data_next  = pend_reg[flush_idx_reg];
            out_last_next  = flush_last_reg && ({1'b0, flush_idx_reg} == last_idx);
            if ({1'b0, flush_idx_reg} == last_idx) begin
               state_next      = IDLE;
               pend_cnt_next   = 3'd0;
               flush_idx_next  = 2'd0;
               flush_last_next = 1'b0;
            end else begin
               flush_idx_next = flush_idx_reg + 2'd1;
            end
         end
      end else if (cur_fire) begin
         held_valid_next = 1'b0;
         case (state_reg)
            IDLE: begin
               if (cur_data == 8'h5F) begin
                  pend_next[pend_cnt_reg[1:0]] = cur_data;
                  pend_cnt_next = pend_cnt_reg + 3'd1;
                  state_next    = U1;
               end else begin
                  out_valid_next = 1'b1;
                  out_data_next  = cur_data;
                  out_last_next  = cur_last;
               end
            end
            U1: begin
               if (cur_data == 8'h5F) begin
                  pend_next[pend_cnt_reg[1:0]] = cur_data;
                  pend_cnt_next = pend_cnt_reg + 3'd1;
                  state_next    = U2;
               end else begin
                  held_valid_next = 1'b1;
               end
            end
            U2: begin
               if (cur_data == 8'h5F) begin
                  if (cur_last) begin
                     pend_next[pend_cnt_reg[1:0]] = cur_data;
                     pend_cnt_next = pend_cnt_reg + 3'd1;
                  end else begin
                     // Oldest underscore of a run is plain text
                     out_valid_next = 1'b1;
                     out_data_next  = 8'h5F;
                     out_last_next  = 1'b0;
                  end
               end else if (cur_data == 8'h30) begin
                  pend_next[pend_cnt_reg[1:0]] = cur_data;
                  pend_cnt_next = pend_cnt_reg + 3'd1;
                  state_next    = Z;
               end else begin
                  held_valid_next = 1'b1;
               end
            end
            Z: begin
               if (cur_hex[4]) begin
                  pend_next[pend_cnt_reg[1:0]] = cur_data;
                  pend_cnt_next = pend_cnt_reg + 3'd1;
                  nib_next      = cur_hex[3:0];
                  state_next    = H1;
               end else begin
                  held_valid_next = 1'b1;
               end
            end
            H1: begin
               if (cur_hex[4]) begin
                  out_valid_next = 1'b1;
                  out_data_next  = {nib_reg, cur_hex[3:0]};
                  out_last_next  = cur_last;
                  pend_cnt_next  = 3'd0;
                  state_next     = IDLE;
                  if (seq_reg != '1) seq_next = seq_reg + 1'b1;
               end else begin
                  held_valid_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase

         if (held_valid_next) begin
            // Mismatch: keep the breaking byte, replay the prefix first
            held_next       = cur_data;
            held_last_next  = cur_last;
            state_next      = FLUSH;
            flush_idx_next  = 2'd0;
            flush_last_next = 1'b0;
            if (lit_reg != '1) lit_next = lit_reg + 1'b1;
         end else if (cur_last && pend_cnt_next != 3'd0) begin
            // Name ends inside a prefix: replay all of it, last flag on the end
            state_next      = FLUSH;
            flush_idx_next  = 2'd0;
            flush_last_next = 1'b1;
            if (lit_reg != '1) lit_next = lit_reg + 1'b1;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign seq_count = seq_reg;
   assign lit_count = lit_reg;

endmodule

// File: tb/tb_name_decoder.sv
// Scoreboard bench for name_decoder: each stimulus pushes its expected output
// bytes, a monitor pops and compares every output handshake.
module tb_name_decoder;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_last;
   logic             out_ready = 1'b1;
   logic [CNT_W-1:0] seq_count;
   logic [CNT_W-1:0] lit_count;

   int               n_vec = 0;
   int               n_bad = 0;
   logic [8:0]       exp_q[$];
   bit               toggle_mode = 1'b0;

   name_decoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .seq_count (seq_count),
      .lit_count (lit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // out_ready changes just after the active edge so it is stable at sampling
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = toggle_mode ? ~out_ready : 1'b1;
      end
   end

   // Monitor: stall stability and scoreboard compare on each output handshake
   initial begin
      logic       stalled;
      logic [8:0] stall_val;
      logic [8:0] e;
      stalled = 1'b0;
      stall_val = 9'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, stall_val});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_byte", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  $display("out byte %h last %b (expected %h last %b)", out_data, out_last, e[7:0], e[8]);
                  chk("out_byte", {23'd0, out_last, out_data}, {23'd0, e});
               end
            end
            stalled   = out_valid && !out_ready;
            stall_val = {out_last, out_data};
         end
      end
   end

   task automatic expect_byte(input logic [7:0] b, input logic l);
      exp_q.push_back({l, b});
   endtask

   // Called just after an active edge; returns just after the accepting edge
   task automatic send(input logic [7:0] b, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = l;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("in_ready_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s, input bit last_on_end);
      for (int i = 0; i < s.len(); i++)
         send(s[i], last_on_end && (i == s.len() - 1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {23'd0, out_last, out_data}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_counters",  {seq_count, lit_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Escape in the middle of a name
      do_reset();
      expect_byte("a", 0); expect_byte(8'h24, 0); expect_byte("b", 1);
      send_str("a__024b", 1);
      drain();
      chk("t1_seq", 32'(seq_count), 32'd1);

      // Run of three underscores, decoded NUL ends the name
      do_reset();
      expect_byte("_", 0); expect_byte(8'h00, 1);
      send_str("___000", 1);
      drain();
      chk("t2_seq", 32'(seq_count), 32'd1);
      chk("t2_lit", 32'(lit_count), 32'd0);

      // Non-hex digit after "__0": replay prefix, then the held byte
      do_reset();
      expect_byte("_", 0); expect_byte("_", 0); expect_byte("0", 0); expect_byte("g", 0);
      send_str("__0", 0);
      send("g", 0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_flush_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      chk("t3_resume_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      drain();
      chk("t3_lit", 32'(lit_count), 32'd1);

      // Name ends one digit short, then a full escape proves IDLE
      do_reset();
      expect_byte("_", 0); expect_byte("_", 0); expect_byte("0", 0); expect_byte("A", 1);
      send_str("__0A", 1);
      expect_byte(8'h41, 0);
      send_str("__041", 0);
      drain();
      chk("t4_seq", 32'(seq_count), 32'd1);

      // Backpressure: out_ready toggling every cycle
      do_reset();
      toggle_mode = 1'b1;
      expect_byte("x", 0); expect_byte(8'h41, 0); expect_byte("y", 1);
      send_str("x__041y", 1);
      drain();
      toggle_mode = 1'b0;
      chk("t5_seq", 32'(seq_count), 32'd1);

      // Reset in the middle of an escape discards the prefix
      do_reset();
      send_str("__0", 0);
      do_reset();
      expect_byte("z", 0);
      send_str("z", 0);
      drain();
      chk("t6_counters", {seq_count, lit_count}, 32'd0);

      // Mismatch in U1, mismatch in H1, lower-case hex
      do_reset();
      expect_byte("_", 0); expect_byte("a", 0);
      expect_byte("_", 0); expect_byte("_", 0); expect_byte("0", 0); expect_byte("F", 0); expect_byte("z", 0);
      expect_byte(8'hFF, 0); expect_byte(8'h9A, 1);
      send_str("_a__0Fz__0ff__09a", 1);
      drain();
      chk("t7_seq", 32'(seq_count), 32'd2);
      chk("t7_lit", 32'(lit_count), 32'd2);

      // Held underscore restarts an escape after the replay
      do_reset();
      expect_byte("_", 0); expect_byte("_", 0); expect_byte("0", 0); expect_byte(8'h41, 1);
      send_str("__0__041", 1);
      drain();
      chk("t8_seq", 32'(seq_count), 32'd1);
      chk("t8_lit", 32'(lit_count), 32'd1);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
